// File: rtl/phase_cmd_sched.sv
// Phase command scheduler: parses a byte stream of phase-write and commit
// commands into a shadow bank. The shadow bank is copied to the active bank
// either immediately or on the next frame-sync rising edge.
module phase_cmd_sched #(
  parameter int NUM_CH    = 4,
  parameter int SYNC_MODE = 1,
  parameter int TIMEOUT   = 50000
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  sync_in,
  output logic [NUM_CH*8-1:0]   phases,
  output logic                  commit_pulse,
  output logic                  cmd_error,
  output logic                  busy
);

  // Counter only has to reach TIMEOUT-1, where the timeout fires
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [7:0] OP_CLEAR  = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_COMMIT = 8'h02;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GET_ADDR  = 2'd1,
    GET_DATA  = 2'd2,
    WAIT_SYNC = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              ready_en;
  logic              sync_prev;
  logic              xfer;
  logic              in_cmd;
  logic              commit_now;
  logic              timeout_hit;
  logic              set_err;
  logic              clr_err;
  logic [CW-1:0]     to_cnt;
  logic [7:0]        addr;
  logic [NUM_CH-1:0] addr_hit;
  logic              addr_ok;

  assign xfer    = rx_valid && rx_ready;
  assign addr_ok = |addr_hit;

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: accepted bytes advance the parser, timeout aborts it
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (rx_data == OP_WRITE) begin
            state_next = GET_ADDR;
          end else if (rx_data == OP_COMMIT) begin
            state_next = WAIT_SYNC;
          end
        end
      end
      GET_ADDR: begin
        if (xfer) begin
          state_next = GET_DATA;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      GET_DATA: begin
        if (xfer || timeout_hit) begin
          state_next = IDLE;
        end
      end
      WAIT_SYNC: begin
        if (commit_now) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State-derived outputs and strobes; ready stays low until the first edge after reset
  always_comb begin
    rx_ready    = ready_en && (state != WAIT_SYNC);
    busy        = (state != IDLE);
    in_cmd      = (state == GET_ADDR) || (state == GET_DATA);
    commit_now  = (state == WAIT_SYNC) &&
                  ((SYNC_MODE != 0) ? (sync_in && !sync_prev) : 1'b1);
    timeout_hit = in_cmd && !xfer && (to_cnt == TO_LAST);
    set_err     = (xfer && (state == IDLE) && (rx_data != OP_CLEAR) &&
                   (rx_data != OP_WRITE) && (rx_data != OP_COMMIT)) ||
                  (xfer && (state == GET_DATA) && !addr_ok) ||
                  timeout_hit;
    clr_err     = xfer && (state == IDLE) && (rx_data == OP_CLEAR);
  end

  // Control datapath: ready enable, sync history, address latch, timeout, error flag
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en     <= 1'b0;
      sync_prev    <= 1'b0;
      commit_pulse <= 1'b0;
      addr         <= 8'd0;
      to_cnt       <= '0;
      cmd_error    <= 1'b0;
    end else begin
      ready_en     <= 1'b1;
      sync_prev    <= sync_in;
      commit_pulse <= commit_now;
      if (xfer && (state == GET_ADDR)) begin
        addr <= rx_data;
      end
      // Any accepted byte restarts the idle count; it only runs mid-command
      if (xfer || !in_cmd || timeout_hit) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_LAST) begin
        to_cnt <= to_cnt + 1'b1;
      end
      // Set has priority over clear
      if (set_err) begin
        cmd_error <= 1'b1;
      end else if (clr_err) begin
        cmd_error <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] shadow;
      logic [7:0] active;

      assign addr_hit[gi]         = (addr == 8'(gi));
      assign phases[8*gi +: 8]    = active;

      // Shadow takes data bytes addressed to this channel; active follows shadow on commit
      always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow <= 8'd0;
          active <= 8'd0;
        end else begin
          if (xfer && (state == GET_DATA) && addr_hit[gi]) begin
            shadow <= rx_data;
          end
          if (commit_now) begin
            active <= shadow;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_phase_cmd_sched.sv
// Directed bench for phase_cmd_sched: one instance with sync-gated commit,
// one with immediate commit, both with a short timeout.
module tb_phase_cmd_sched;

  localparam int NCH = 4;
  localparam int TO  = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]       data_s = 8'd0, data_i = 8'd0;
  logic             valid_s = 1'b0, valid_i = 1'b0;
  logic             ready_s, ready_i;
  logic             sync_s = 1'b0, sync_i = 1'b0;
  logic [NCH*8-1:0] phases_s, phases_i;
  logic             pulse_s, pulse_i, err_s, err_i, busy_s, busy_i;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  phase_cmd_sched #(.NUM_CH(NCH), .SYNC_MODE(1), .TIMEOUT(TO)) dut_s (
    .sys_clk(clk), .rst_n(rst_n), .rx_data(data_s), .rx_valid(valid_s),
    .rx_ready(ready_s), .sync_in(sync_s), .phases(phases_s),
    .commit_pulse(pulse_s), .cmd_error(err_s), .busy(busy_s)
  );

  phase_cmd_sched #(.NUM_CH(NCH), .SYNC_MODE(0), .TIMEOUT(TO)) dut_i (
    .sys_clk(clk), .rst_n(rst_n), .rx_data(data_i), .rx_valid(valid_i),
    .rx_ready(ready_i), .sync_in(sync_i), .phases(phases_i),
    .commit_pulse(pulse_i), .cmd_error(err_i), .busy(busy_i)
  );

  // Offer one byte to the chosen instance; returns 1 time unit after the transfer edge
  task automatic send(input bit imm, input logic [7:0] b);
    bit done;
    done = 1'b0;
    @(negedge clk);
    if (imm) begin data_i = b; valid_i = 1'b1; end
    else     begin data_s = b; valid_s = 1'b1; end
    for (int n = 0; n < 50 && !done; n++) begin
      if ((imm ? ready_i : ready_s) === 1'b1) done = 1'b1;
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    #1;
    valid_i = 1'b0;
    valid_s = 1'b0;
    tests++;
    if (!done) begin fails++; $display("FAIL send_accept byte=%h got=not_accepted exp=accepted", b); end
    else $display("[TB] byte %h sent to %s", b, imm ? "dut_i" : "dut_s");
  endtask

  // One-cycle sync pulse on the sync-gated instance; returns at the negedge after it
  task automatic pulse_sync();
    @(negedge clk);
    sync_s = 1'b1;
    @(negedge clk);
    sync_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (ready_s !== 1'b0) begin fails++; $display("FAIL reset_ready_s got=%b exp=0", ready_s); end
    tests++; if (ready_i !== 1'b0) begin fails++; $display("FAIL reset_ready_i got=%b exp=0", ready_i); end
    tests++; if (phases_s !== 32'h0) begin fails++; $display("FAIL reset_phases got=%h exp=%h", phases_s, 32'h0); end
    tests++; if (busy_s !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy_s); end
    tests++; if (err_s !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_s); end
    tests++; if (pulse_s !== 1'b0) begin fails++; $display("FAIL reset_pulse got=%b exp=0", pulse_s); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (ready_s !== 1'b1) begin fails++; $display("FAIL post_reset_ready_s got=%b exp=1", ready_s); end
    tests++; if (ready_i !== 1'b1) begin fails++; $display("FAIL post_reset_ready_i got=%b exp=1", ready_i); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_sync_commit();
    send(0, 8'h01); send(0, 8'h02); send(0, 8'h5A);
    @(negedge clk);
    tests++; if (phases_s !== 32'h0) begin fails++; $display("FAIL shadow_leak got=%h exp=%h", phases_s, 32'h0); end
    tests++; if (busy_s !== 1'b0) begin fails++; $display("FAIL write_idle_busy got=%b exp=0", busy_s); end
    send(0, 8'h02);
    @(negedge clk);
    tests++; if (busy_s !== 1'b1) begin fails++; $display("FAIL wait_busy got=%b exp=1", busy_s); end
    tests++; if (ready_s !== 1'b0) begin fails++; $display("FAIL wait_ready got=%b exp=0", ready_s); end
    repeat (3) @(negedge clk);
    tests++; if (phases_s !== 32'h0) begin fails++; $display("FAIL commit_early got=%h exp=%h", phases_s, 32'h0); end
    pulse_sync();
    tests++; if (pulse_s !== 1'b1) begin fails++; $display("FAIL commit_pulse got=%b exp=1", pulse_s); end
    tests++; if (phases_s !== 32'h005A0000) begin fails++; $display("FAIL commit_phases got=%h exp=%h", phases_s, 32'h005A0000); end
    tests++; if (busy_s !== 1'b0) begin fails++; $display("FAIL commit_busy got=%b exp=0", busy_s); end
    @(negedge clk);
    tests++; if (pulse_s !== 1'b0) begin fails++; $display("FAIL pulse_width got=%b exp=0", pulse_s); end
    $display("[TB] test_sync_commit done");
  endtask

  task automatic test_sync_ignored();
    pulse_sync();
    tests++; if (pulse_s !== 1'b0) begin fails++; $display("FAIL idle_sync_commit got=%b exp=0", pulse_s); end
    send(0, 8'h02);
    repeat (3) @(negedge clk);
    tests++; if (busy_s !== 1'b1) begin fails++; $display("FAIL edge_remembered got=%b exp=1", busy_s); end
    pulse_sync();
    tests++; if (pulse_s !== 1'b1) begin fails++; $display("FAIL recommit_pulse got=%b exp=1", pulse_s); end
    $display("[TB] test_sync_ignored done");
  endtask

  task automatic test_immediate();
    send(1, 8'h01); send(1, 8'h00); send(1, 8'h11);
    repeat (2) @(negedge clk);
    tests++; if (phases_i !== 32'h0) begin fails++; $display("FAIL imm_no_commit got=%h exp=%h", phases_i, 32'h0); end
    send(1, 8'h02);
    tests++; if (ready_i !== 1'b0) begin fails++; $display("FAIL imm_backpressure got=%b exp=0", ready_i); end
    tests++; if (phases_i !== 32'h0) begin fails++; $display("FAIL imm_early got=%h exp=%h", phases_i, 32'h0); end
    @(posedge clk); #1;
    tests++; if (phases_i !== 32'h00000011) begin fails++; $display("FAIL imm_phases got=%h exp=%h", phases_i, 32'h00000011); end
    tests++; if (pulse_i !== 1'b1) begin fails++; $display("FAIL imm_pulse got=%b exp=1", pulse_i); end
    tests++; if (ready_i !== 1'b1) begin fails++; $display("FAIL imm_ready got=%b exp=1", ready_i); end
    @(posedge clk); #1;
    tests++; if (pulse_i !== 1'b0) begin fails++; $display("FAIL imm_pulse_width got=%b exp=0", pulse_i); end
    $display("[TB] test_immediate done");
  endtask

  task automatic test_bad_addr();
    send(0, 8'h01); send(0, 8'h07); send(0, 8'h33);
    @(negedge clk);
    tests++; if (err_s !== 1'b1) begin fails++; $display("FAIL bad_addr_err got=%b exp=1", err_s); end
    tests++; if (busy_s !== 1'b0) begin fails++; $display("FAIL bad_addr_idle got=%b exp=0", busy_s); end
    send(0, 8'h02);
    pulse_sync();
    tests++; if (phases_s !== 32'h005A0000) begin fails++; $display("FAIL bad_addr_shadow got=%h exp=%h", phases_s, 32'h005A0000); end
    send(0, 8'h00);
    @(negedge clk);
    tests++; if (err_s !== 1'b0) begin fails++; $display("FAIL err_clear got=%b exp=0", err_s); end
    send(0, 8'h77);
    @(negedge clk);
    tests++; if (err_s !== 1'b1) begin fails++; $display("FAIL bad_opcode_err got=%b exp=1", err_s); end
    send(0, 8'h00);
    @(negedge clk);
    tests++; if (err_s !== 1'b0) begin fails++; $display("FAIL err_clear2 got=%b exp=0", err_s); end
    $display("[TB] test_bad_addr done");
  endtask

  task automatic test_timeout();
    send(0, 8'h01);
    repeat (TO - 1) @(posedge clk);
    #1;
    tests++; if (busy_s !== 1'b1) begin fails++; $display("FAIL timeout_early got=%b exp=1", busy_s); end
    tests++; if (err_s !== 1'b0) begin fails++; $display("FAIL timeout_err_early got=%b exp=0", err_s); end
    @(posedge clk); #1;
    tests++; if (busy_s !== 1'b0) begin fails++; $display("FAIL timeout_idle got=%b exp=0", busy_s); end
    tests++; if (err_s !== 1'b1) begin fails++; $display("FAIL timeout_err got=%b exp=1", err_s); end
    send(0, 8'h01); send(0, 8'h00); send(0, 8'h44); send(0, 8'h02);
    pulse_sync();
    tests++; if (phases_s !== 32'h005A0044) begin fails++; $display("FAIL post_timeout_phases got=%h exp=%h", phases_s, 32'h005A0044); end
    send(0, 8'h00);
    $display("[TB] test_timeout done");
  endtask

  task automatic test_byte_wins();
    send(0, 8'h01);
    repeat (TO - 1) @(posedge clk);
    #1;
    send(0, 8'h00);
    tests++; if (busy_s !== 1'b1) begin fails++; $display("FAIL byte_wins_state got=%b exp=1", busy_s); end
    tests++; if (err_s !== 1'b0) begin fails++; $display("FAIL byte_wins_err got=%b exp=0", err_s); end
    send(0, 8'h22);
    @(negedge clk);
    tests++; if (busy_s !== 1'b0) begin fails++; $display("FAIL byte_wins_done got=%b exp=0", busy_s); end
    $display("[TB] test_byte_wins done");
  endtask

  task automatic test_backpressure();
    send(0, 8'h02);
    @(negedge clk);
    data_s  = 8'h01;
    valid_s = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests++; if (ready_s !== 1'b0) begin fails++; $display("FAIL bp_ready cycle=%0d got=%b exp=0", k, ready_s); end
      @(negedge clk);
    end
    sync_s = 1'b1;
    @(negedge clk);
    sync_s = 1'b0;
    tests++; if (pulse_s !== 1'b1) begin fails++; $display("FAIL bp_commit got=%b exp=1", pulse_s); end
    tests++; if (ready_s !== 1'b1) begin fails++; $display("FAIL bp_ready_after got=%b exp=1", ready_s); end
    @(posedge clk); #1;
    valid_s = 1'b0;
    tests++; if (busy_s !== 1'b1) begin fails++; $display("FAIL bp_byte_kept got=%b exp=1", busy_s); end
    send(0, 8'h03); send(0, 8'h77); send(0, 8'h02);
    pulse_sync();
    tests++; if (phases_s !== 32'h775A0022) begin fails++; $display("FAIL bp_phases got=%h exp=%h", phases_s, 32'h775A0022); end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_reset_wait_sync();
    send(0, 8'h55);
    send(0, 8'h02);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (phases_s !== 32'h0) begin fails++; $display("FAIL async_phases got=%h exp=%h", phases_s, 32'h0); end
    tests++; if (busy_s !== 1'b0) begin fails++; $display("FAIL async_busy got=%b exp=0", busy_s); end
    tests++; if (ready_s !== 1'b0) begin fails++; $display("FAIL async_ready got=%b exp=0", ready_s); end
    tests++; if (err_s !== 1'b0) begin fails++; $display("FAIL async_err got=%b exp=0", err_s); end
    tests++; if (phases_i !== 32'h0) begin fails++; $display("FAIL async_phases_i got=%h exp=%h", phases_i, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_sync();
    tests++; if (pulse_s !== 1'b0) begin fails++; $display("FAIL reset_no_commit got=%b exp=0", pulse_s); end
    tests++; if (busy_s !== 1'b0) begin fails++; $display("FAIL reset_abandon got=%b exp=0", busy_s); end
    @(negedge clk);
    tests++; if (phases_s !== 32'h0) begin fails++; $display("FAIL reset_phases_after got=%h exp=%h", phases_s, 32'h0); end
    $display("[TB] test_reset_wait_sync done");
  endtask

  initial begin
    test_reset();
    test_sync_commit();
    test_sync_ignored();
    test_immediate();
    test_bad_addr();
    test_timeout();
    test_byte_wins();
    test_backpressure();
    test_reset_wait_sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
